flag_branch_unit: RTL
=====================

# flag_branch_unit

Holds the processor's Z/V/N condition flags produced by the 16-bit ALU and resolves conditional branches against them. Sits between EX (ALU result and `Flag` output) and ID (branch decode). It forwards same-cycle flag updates, computes the branch target, and issues a registered one-cycle redirect pulse to fetch. Also keeps saturating taken/not-taken branch counters for debug.

## Interface
- No parameters; all widths fixed by the ISA (16-bit data/PC, 4-bit ALU opcode, 3-bit condition code).
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `stall`  in  1  pipeline hold; freezes all state updates
- `ex_valid`  in  1  EX holds a real ALU instruction this cycle
- `ex_aluop`  in  4  ALU opcode of the EX instruction
- `ex_flag`  in  3  ALU flag output, {Z,V,N}
- `br_valid`  in  1  ID holds a branch this cycle
- `br_is_reg`  in  1  1 = BR (register target), 0 = B (PC-relative)
- `br_ccc`  in  3  condition code
- `br_pc_plus2`  in  16  PC of branch + 2
- `br_imm9`  in  9  signed word offset (B only)
- `br_reg`  in  16  register target (BR only)
- `flags`  out  3  architectural flag register, {Z,V,N}
- `redirect`  out  1  one-cycle pulse: fetch must load `target`
- `target`  out  16  redirect address, valid while `redirect`=1
- `taken_cnt`  out  16  saturating count of taken branches
- `ntaken_cnt`  out  16  saturating count of not-taken branches

## Operation
- Flag write masks by `ex_aluop`:
  - 0000 ADD, 0001 SUB: write Z, V, N.
  - 0010 XOR, 0100 SLL, 0101 SRA, 0110 ROR: write Z only.
  - 0011 RED, 0111 PADDSB, 1xxx: write none.
- Unmasked bits keep their old value. Update only when `ex_valid`=1 and `stall`=0.
- Effective flags for resolution (`eff`): the register merged with the masked `ex_flag` when `ex_valid`=1. This forwards EX results to a branch in ID in the same cycle.
- Conditions on `eff`:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GTE: Z | !N
  - 101 LTE: Z | N
  - 110 OV: V
  - 111: always
- Target arithmetic:
  - B: `br_pc_plus2` + (sign-extended `br_imm9` << 1), modulo 2^16, wrapping with no flag.
  - BR: `br_reg`.
- A branch is accepted when `br_valid`=1, `stall`=0 and `redirect`=0. When `redirect`=1, the ID instruction is wrong-path and is ignored entirely: no counter change, no redirect.
- Accepted and condition true: next cycle `redirect`=1 and `target`=computed address; `taken_cnt` +1.
- Accepted and condition false: no redirect; `ntaken_cnt` +1.
- Both counters saturate at 16'hFFFF.
- FSM has two states:
  - IDLE: `redirect`=0. An accepted taken branch goes to REDIR.
  - REDIR: `redirect`=1. Returns to IDLE on the next unstalled edge. While `stall`=1 it stays in REDIR, holding `redirect` and `target`.

## Timing
- Reset (async, on `rst_n` low): `flags`=000, `redirect`=0, `target`=0000, both counters 0, FSM=IDLE. Outputs change immediately on reset assertion, with no clock needed.
- Flag update latency: 1 edge. A branch in the same cycle sees the new value through forwarding.
- Branch-to-redirect latency: exactly 1 edge. The redirect pulse is 1 cycle wide unless stretched by `stall`.
- `stall`=1: no flag write, no counter change, no branch acceptance, `redirect`/`target` held.
- Reset asserted mid-REDIR: redirect drops at once and the FSM returns to IDLE.
- Flag update and branch in the same cycle: both take effect. The branch uses forwarded flags, and the register takes the new flags.

## Test plan
- Reset: drive `rst_n`=0 mid-cycle -> `flags`=000, `redirect`=0, `target`=0000 and counters 0 with no clock edge.
- Forwarding: flags=000; EX ADD with `ex_flag`=100 (Z) and same-cycle ID B EQ, imm9=9'h1FE, pc_plus2=16'h0010 -> next cycle `redirect`=1, `target`=16'h000C, `flags`=100, `taken_cnt`=1.
- Masking: flags=011; EX XOR with `ex_flag`=100 -> `flags`=111. Then EX PADDSB with `ex_flag`=000 -> `flags` stays 111.
- Shadow/not-taken:
  - Taken BR to 16'hABCD -> `redirect`=1, `target`=16'hABCD.
  - A branch presented during the redirect cycle is ignored, with counters unchanged.
  - A later NE branch with Z=1 -> no redirect, `ntaken_cnt`+1.
- Stall/wrap:
  - B with pc_plus2=16'hFFFE, imm9=9'h001 -> `target`=16'h0000.
  - Assert `stall` during REDIR for 3 cycles -> `redirect` held 4 cycles total.
  - Preload counters to 16'hFFFF -> they remain 16'hFFFF.

Source files
------------

// File: rtl/flag_branch_unit.sv
// flag_branch_unit
//
// Holds the Z/V/N condition flags written by the 16-bit ALU and resolves
// conditional branches against them. It sits between EX and ID. A flag
// update in EX is forwarded to a branch in ID in the same cycle. A taken
// branch produces a registered redirect pulse one edge later. The unit also
// keeps saturating taken/not-taken counters for debug.
//
// Ports
//   clk, rst_n    rising-edge clock, asynchronous active-low reset
//   stall         pipeline hold: freezes every state update
//   ex_valid      EX holds a real ALU instruction
//   ex_aluop      ALU opcode, selects which flags are written
//   ex_flag       ALU flag output {Z,V,N}
//   br_valid      ID holds a branch
//   br_is_reg     1 = BR (register target), 0 = B (PC-relative)
//   br_ccc        condition code
//   br_pc_plus2   branch PC + 2
//   br_imm9       signed word offset for B
//   br_reg        register target for BR
//   flags         architectural flag register {Z,V,N}
//   redirect      fetch must load target (one cycle, stretched by stall)
//   target        redirect address, valid while redirect = 1
//   taken_cnt     saturating count of taken branches
//   ntaken_cnt    saturating count of not-taken branches
//
// Branch handshake: ID offers a branch with br_valid. The branch is consumed
// (accepted) on a rising edge when br_valid = 1, stall = 0 and redirect = 0.
// There is no ready output. While redirect = 1 the ID instruction is
// wrong-path, and the unit drops it without any side effect.

module flag_branch_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        ex_valid,
  input  logic [3:0]  ex_aluop,
  input  logic [2:0]  ex_flag,
  input  logic        br_valid,
  input  logic        br_is_reg,
  input  logic [2:0]  br_ccc,
  input  logic [15:0] br_pc_plus2,
  input  logic [8:0]  br_imm9,
  input  logic [15:0] br_reg,
  output logic [2:0]  flags,
  output logic        redirect,
  output logic [15:0] target,
  output logic [15:0] taken_cnt,
  output logic [15:0] ntaken_cnt
);

  typedef enum logic {
    IDLE  = 1'b0,
    REDIR = 1'b1
  } state_t;

  state_t      state_q;
  state_t      state_d;

  logic [2:0]  wr_mask;     // which of {Z,V,N} the EX opcode writes
  logic [2:0]  eff;         // register merged with forwarded EX flags
  logic        eff_z;
  logic        eff_v;
  logic        eff_n;
  logic        cond_true;
  logic [15:0] b_target;
  logic [15:0] br_target;
  logic        br_accept;
  logic        br_taken;
  logic        br_ntaken;

  // Flag write mask by opcode
  always_comb begin
    wr_mask = 3'b000;
    case (ex_aluop)
      4'b0000, 4'b0001:                   wr_mask = 3'b111; // ADD, SUB
      4'b0010, 4'b0100, 4'b0101, 4'b0110: wr_mask = 3'b100; // XOR, shifts
      default:                            wr_mask = 3'b000; // RED, PADDSB, 1xxx
    endcase
  end

  // Forwarding: a branch in ID sees the flags EX is about to write.
  assign eff   = ex_valid ? ((flags & ~wr_mask) | (ex_flag & wr_mask)) : flags;
  assign eff_z = eff[2];
  assign eff_v = eff[1];
  assign eff_n = eff[0];

  always_comb begin
    cond_true = 1'b0;
    case (br_ccc)
      3'b000:  cond_true = ~eff_z;
      3'b001:  cond_true = eff_z;
      3'b010:  cond_true = ~eff_z & ~eff_n;
      3'b011:  cond_true = eff_n;
      3'b100:  cond_true = eff_z | ~eff_n;
      3'b101:  cond_true = eff_z | eff_n;
      3'b110:  cond_true = eff_v;
      default: cond_true = 1'b1;
    endcase
  end

  // Word offset: sign-extend imm9 and scale by 2. The add wraps modulo 2^16.
  assign b_target  = br_pc_plus2 + {{6{br_imm9[8]}}, br_imm9, 1'b0};
  assign br_target = br_is_reg ? br_reg : b_target;

  assign br_accept = br_valid & ~stall & (state_q == IDLE);
  assign br_taken  = br_accept & cond_true;
  assign br_ntaken = br_accept & ~cond_true;

  // Redirect FSM
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (br_taken) state_d = REDIR;
      REDIR:   if (!stall)   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign redirect = (state_q == REDIR);

  // Flag register. eff already holds the merged value, so unmasked bits
  // keep their old value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags <= 3'b000;
    end else if (ex_valid && !stall) begin
      flags <= eff;
    end
  end

  // Target is loaded only by a taken branch. It is held through a stalled
  // REDIR and afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= 16'h0000;
    end else if (br_taken) begin
      target <= br_target;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_cnt  <= 16'h0000;
      ntaken_cnt <= 16'h0000;
    end else begin
      if (br_taken && (taken_cnt != 16'hFFFF)) begin
        taken_cnt <= taken_cnt + 16'd1;
      end
      if (br_ntaken && (ntaken_cnt != 16'hFFFF)) begin
        ntaken_cnt <= ntaken_cnt + 16'd1;
      end
    end
  end

endmodule
